// File: rtl/line_drawer.sv
// Bresenham line rasteriser that feeds the VGA framebuffer write port, one pixel per clock.
// Optional macro LINE_DRAWER_CLIP_EN suppresses pixel_write for off-screen pixels.
module line_drawer #(
    parameter int HRES = 640,
    parameter int VRES = 480
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               start,
    input  logic signed [11:0] x0,
    input  logic signed [11:0] y0,
    input  logic signed [11:0] x1,
    input  logic signed [11:0] y1,
    input  logic               color,
    output logic               busy,
    output logic               done,
    output logic signed [11:0] x,
    output logic signed [11:0] y,
    output logic               pixel_color,
    output logic               pixel_write
);

    localparam int unsigned CW  = 12;
    localparam int unsigned DW  = 13;
    localparam int unsigned EW  = 14;
    localparam int unsigned E2W = 15;

`ifdef LINE_DRAWER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic signed [EW-1:0] ERR_ZERO = '0;
    localparam logic signed [CW-1:0] ONE      = 12'sd1;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t                state, state_d;
    logic signed [CW-1:0]  x0_q, y0_q, x1_q, y1_q;
    logic signed [CW-1:0]  x0_d, y0_d, x1_d, y1_d;
    logic signed [DW-1:0]  dx_q, dy_q, dx_d, dy_d;
    logic                  sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic signed [CW-1:0]  x_d, y_d;
    logic                  busy_d, done_d, pixel_color_d, pixel_write_d;

    logic signed [DW-1:0]  diff_x, diff_y, abs_x, abs_y;
    logic signed [E2W-1:0] e2;
    logic                  step_x, step_y, at_end;

    function automatic logic on_screen(input logic signed [CW-1:0] px,
                                       input logic signed [CW-1:0] py);
        return !px[CW-1] && (int'(px) < HRES) && !py[CW-1] && (int'(py) < VRES);
    endfunction

    // Setup-time deltas (13-bit signed, never overflow for 12-bit endpoints)
    assign diff_x = DW'(x1_q) - DW'(x0_q);
    assign diff_y = DW'(y1_q) - DW'(y0_q);
    assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
    assign abs_y  = diff_y[DW-1] ? -diff_y : diff_y;

    // Both Bresenham tests use the error value from the start of the cycle
    assign e2     = {err_q, 1'b0};
    assign step_x = (e2 >= E2W'(dy_q));
    assign step_y = (e2 <= E2W'(dx_q));
    assign at_end = (x == x1_q) && (y == y1_q);

    always_comb begin
        state_d       = state;
        x0_d          = x0_q;
        y0_d          = y0_q;
        x1_d          = x1_q;
        y1_d          = y1_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        sx_neg_d      = sx_neg_q;
        sy_neg_d      = sy_neg_q;
        err_d         = err_q;
        x_d           = x;
        y_d           = y;
        pixel_color_d = pixel_color;

        unique case (state)
            IDLE: begin
                if (start) begin
                    x0_d          = x0;
                    y0_d          = y0;
                    x1_d          = x1;
                    y1_d          = y1;
                    pixel_color_d = color;
                    state_d       = SETUP;
                end
            end
            SETUP: begin
                dx_d     = abs_x;
                dy_d     = -abs_y;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                err_d    = EW'(abs_x) - EW'(abs_y);
                x_d      = x0_q;
                y_d      = y0_q;
                state_d  = DRAW;
            end
            DRAW: begin
                if (at_end) begin
                    state_d = DONE;
                end else begin
                    if (step_x) x_d = sx_neg_q ? (x - ONE) : (x + ONE);
                    if (step_y) y_d = sy_neg_q ? (y - ONE) : (y + ONE);
                    err_d = err_q + (step_x ? EW'(dy_q) : ERR_ZERO)
                                  + (step_y ? EW'(dx_q) : ERR_ZERO);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the pixel shown
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        pixel_write_d = (state_d == DRAW) && (!CLIP_EN || on_screen(x_d, y_d));
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            err_q       <= '0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
        end else begin
            state       <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            err_q       <= err_d;
            x           <= x_d;
            y           <= y_d;
            busy        <= busy_d;
            done        <= done_d;
            pixel_color <= pixel_color_d;
            pixel_write <= pixel_write_d;
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Testbench for line_drawer: table of directed lines, hand-written corner sequences and random lines
// checked against a software line model.
module tb_line_drawer;

    logic               clk50;
    logic               reset;
    logic               start;
    logic signed [11:0] x0, y0, x1, y1;
    logic               color;
    logic               busy, done;
    logic signed [11:0] x, y;
    logic               pixel_color, pixel_write;

    line_drawer #(.HRES(640), .VRES(480)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .color       (color),
        .busy        (busy),
        .done        (done),
        .x           (x),
        .y           (y),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_x[$], exp_y[$];
    int got_x[$], got_y[$];

    typedef struct {
        int x0, y0, x1, y1;
        bit col;
        int writes;
        int done_cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic bit visible(input int px, input int py);
`ifdef LINE_DRAWER_CLIP_EN
        return (px >= 0) && (px < 640) && (py >= 0) && (py < 480);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Plain integer Bresenham walk producing the list of written pixels
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, cx, cy;
        exp_x.delete();
        exp_y.delete();
        dx  = iabs(ax1 - ax0);
        dy  = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        cx  = ax0;
        cy  = ay0;
        for (int guard = 0; guard < 10000; guard++) begin
            if (visible(cx, cy)) begin
                exp_x.push_back(cx);
                exp_y.push_back(cy);
            end
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    task automatic run_line(input string name, input int ax0, input int ay0, input int ax1,
                            input int ay1, input bit col, input int exp_writes,
                            input int exp_done, input bit poke);
        int done_cyc, col_bad, overlap, mism, n;
        got_x.delete();
        got_y.delete();
        build_model(ax0, ay0, ax1, ay1);
        @(negedge clk50);
        x0 = 12'(ax0); y0 = 12'(ay0); x1 = 12'(ax1); y1 = 12'(ay1);
        color = col;
        start = 1'b1;
        @(negedge clk50);
        start = poke;
        x0 = 12'($urandom); y0 = 12'($urandom); x1 = 12'($urandom); y1 = 12'($urandom);
        color = ~col;
        check({name, "_setup_busy"}, int'(busy), 1);
        done_cyc = 0; col_bad = 0; overlap = 0;
        for (int c = 1; c <= exp_done + 20; c++) begin
            @(negedge clk50);
            start = poke;
            if (pixel_write) begin
                got_x.push_back(int'(x));
                got_y.push_back(int'(y));
                if (pixel_color != col) col_bad++;
            end
            if (pixel_write && done) overlap++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_writes"}, got_x.size(), exp_writes);
        mism = 0;
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < n; i++)
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) mism++;
        mism += iabs(got_x.size() - exp_x.size());
        check({name, "_pixels"}, mism, 0);
        check({name, "_color"}, col_bad, 0);
        check({name, "_done_write_overlap"}, overlap, 0);
        @(negedge clk50);
        start = 1'b0;
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_done_pulse"}, int'(done), 0);
    endtask

    vec_t vecs[7];
    int   sr_x[5];
    int   sr_y[5];

    initial begin
        int wr, dcnt, rx0, ry0, rx1, ry1, nn;
        reset = 1'b0;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        color = 1'b0;

        vecs[0] = '{x0:5,   y0:7,   x1:5,   y1:7,   col:1'b1, writes:1,  done_cyc:2};
        vecs[1] = '{x0:0,   y0:0,   x1:3,   y1:0,   col:1'b0, writes:4,  done_cyc:5};
        vecs[2] = '{x0:2,   y0:4,   x1:0,   y1:0,   col:1'b1, writes:5,  done_cyc:6};
        vecs[3] = '{x0:0,   y0:0,   x1:2,   y1:2,   col:1'b1, writes:3,  done_cyc:4};
        vecs[4] = '{x0:10,  y0:20,  x1:10,  y1:15,  col:1'b1, writes:6,  done_cyc:7};
        vecs[5] = '{x0:100, y0:100, x1:110, y1:103, col:1'b0, writes:11, done_cyc:12};
        vecs[6] = '{x0:639, y0:479, x1:630, y1:479, col:1'b1, writes:10, done_cyc:11};
        sr_x = '{2, 1, 1, 0, 0};
        sr_y = '{4, 3, 2, 1, 0};

        repeat (2) @(negedge clk50);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_write", int'(pixel_write), 0);
        check("reset_xy", int'(x) + int'(y), 0);
        check("reset_color", int'(pixel_color), 0);
        reset = 1'b1;
        @(negedge clk50);

        for (int i = 0; i < 7; i++)
            run_line($sformatf("vec%0d", i), vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                     vecs[i].col, vecs[i].writes, vecs[i].done_cyc, 1'b0);

        // Steep reverse line against the literal pixel order
        run_line("steep_rev", 2, 4, 0, 0, 1'b1, 5, 6, 1'b0);
        wr = 0;
        for (int i = 0; i < 5 && i < got_x.size(); i++)
            if (got_x[i] == sr_x[i] && got_y[i] == sr_y[i]) wr++;
        check("steep_rev_literal", wr, 5);

        // start held high through DRAW and DONE is ignored
        run_line("poke", 0, 0, 2, 2, 1'b1, 3, 4, 1'b1);

        // Off-screen left endpoint: done timing unchanged either way
`ifdef LINE_DRAWER_CLIP_EN
        run_line("clip", -2, 0, 1, 0, 1'b1, 2, 5, 1'b0);
`else
        run_line("clip", -2, 0, 1, 0, 1'b1, 4, 5, 1'b0);
`endif
        check("clip_last_x", (got_x.size() > 0) ? got_x[got_x.size()-1] : -99, 1);

        // Reset in the middle of DRAW
        @(negedge clk50);
        x0 = 12'(0); y0 = 12'(0); x1 = 12'(9); y1 = 12'(0); color = 1'b1; start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
        wr = 0;
        for (int c = 0; c < 20 && wr < 3; c++) begin
            @(negedge clk50);
            if (pixel_write) wr++;
        end
        check("pre_reset_writes", wr, 3);
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_write", int'(pixel_write), 0);
        check("abort_color", int'(pixel_color), 0);
        check("abort_x", int'(x), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk50);
        reset = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk50);
            if (done || busy || pixel_write) dcnt++;
        end
        check("abort_quiet", dcnt, 0);
        run_line("after_abort", 0, 0, 9, 0, 1'b1, 10, 11, 1'b0);

        // Random lines, some partly off-screen
        for (int i = 0; i < 20; i++) begin
            rx0 = int'($urandom_range(0, 740)) - 40;
            ry0 = int'($urandom_range(0, 560)) - 40;
            rx1 = int'($urandom_range(0, 740)) - 40;
            ry1 = int'($urandom_range(0, 560)) - 40;
            if (i % 5 == 0) begin rx1 = rx0; end
            nn = ((iabs(rx1 - rx0) > iabs(ry1 - ry0)) ? iabs(rx1 - rx0) : iabs(ry1 - ry0)) + 1;
            build_model(rx0, ry0, rx1, ry1);
            run_line($sformatf("rand%0d", i), rx0, ry0, rx1, ry1, 1'($urandom),
                     exp_x.size(), nn + 1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
# line_drawer

Bresenham line rasteriser that sits directly upstream of the black-and-white VGA framebuffer. It accepts a pair of endpoints and a colour through a start/busy/done handshake. It then emits one pixel per clock on the framebuffer's write port (x, y, pixel_color, pixel_write) until the line is complete. Output coordinates use the framebuffer's signed 12-bit format, so the ports connect one-to-one.

## Interface
Parameters:
- HRES, 640, active width in pixels; used by clipping.
- VRES, 480, active height in pixels; used by clipping.

Ports:
- clk50  in  1  system clock; 50 MHz, the same clock as the framebuffer.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request to draw; sampled only in IDLE.
- x0, y0  in  12 signed  start endpoint.
- x1, y1  in  12 signed  end endpoint.
- color  in  1  line colour; 1 = white.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse after the last pixel.
- x, y  out  12 signed  current pixel; goes to the framebuffer x, y.
- pixel_color  out  1  latched colour.
- pixel_write  out  1  write strobe; goes to the framebuffer pixel_write.

## Operation
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - busy=0, pixel_write=0.
  - If start=1 at a rising edge: latch x0, y0, x1, y1, color and go to SETUP.
- SETUP (1 cycle), computing with 13-bit signed intermediates:
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy, 14-bit signed.
  - cur_x = x0, cur_y = y0.
  - Go to DRAW.
- DRAW, one pixel per cycle:
  - x=cur_x, y=cur_y, pixel_write=1 (subject to clipping).
  - If cur_x==x1 and cur_y==y1, go to DONE.
  - Otherwise let e2 = 2·err, 15-bit signed, and apply both tests in the same cycle using the old err:
    - if e2 ≥ dy: err += dy, cur_x += sx;
    - if e2 ≤ dx: err += dx, cur_y += sy.
- DONE (1 cycle): done=1, busy=1, pixel_write=0; go to IDLE.
- Pixel count N = max(|x1-x0|, |y1-y0|) + 1.
- Degenerate line (x0==x1 and y0==y1) gives exactly one pixel.
- start while busy, including in the DONE cycle, is ignored. Inputs may change freely after acceptance.
- pixel_color is constant for the whole line and equals the colour latched at start.
- Coordinate arithmetic is signed 12-bit. Endpoints are legal in [-2048, 2047]; dx and dy never overflow 13 bits.
- Reset asserted mid-operation aborts immediately: state goes to IDLE, and no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, pixel_write=0, x=0, y=0, pixel_color=0, state IDLE.
- Edges are numbered from E0, the edge that samples start=1.
  - SETUP occupies the cycle after E0.
  - Pixel i (i = 0..N-1) is presented after edge E(1+i); the framebuffer captures it at E(2+i).
  - done is high in the cycle after E(N+1).
- Latency from start to done is N+1 cycles. A new start is accepted in the cycle after done.
- done and pixel_write are never high in the same cycle.
- busy falls together with done falling.

## Configuration
- Macro: LINE_DRAWER_CLIP_EN.
- Defined: pixel_write is forced to 0 in DRAW whenever x<0, x≥HRES, y<0 or y≥VRES. Stepping continues, so cycle count and done timing are unchanged.
- Undefined: pixel_write=1 on every DRAW cycle. Off-screen coordinates are passed through unfiltered; the caller is responsible for keeping endpoints on screen.

## Test plan
- Point (5,7)→(5,7), color=1: exactly one pixel_write at (5,7) with pixel_color=1; done 2 edges after E0.
- Horizontal (0,0)→(3,0): writes (0,0), (1,0), (2,0), (3,0) on consecutive cycles; done in the following cycle; busy low the cycle after that.
- Steep reverse (2,4)→(0,0): writes (2,4), (1,3), (1,2), (0,1), (0,0) in that order; done follows.
- start pulsed again during DRAW and during DONE of a line (0,0)→(2,2): second request ignored; only 3 pixels; one done pulse.
- Clip (-2,0)→(1,0) with LINE_DRAWER_CLIP_EN: pixel_write only for x=0 and x=1; done still at E5. Without the macro: 4 writes, including x=-2 and x=-1.
- Reset driven low during DRAW of (0,0)→(9,0) after 3 pixels: all outputs go to 0 immediately; no done; a fresh start then draws a full line.
